// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock using a
// single (WIDTH+1)-bit trial subtraction whose borrow chooses restore or keep.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Handshake: start is taken only in IDLE or DONE (operands captured on that
    // edge); done pulses for one cycle when results are valid, and the results
    // then hold until the next completed operation.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   p;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // Extra guard bit makes the borrow explicit regardless of operand values.
    always_comb begin
        p      = {r, q[WIDTH-1]};
        diff   = {1'b0, p} - {2'b00, d};
        borrow = diff[WIDTH+1];
        r_next = borrow ? p[WIDTH-1:0] : diff[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r <= '0;
                        q <= dividend;
                        d <= divisor;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= S_RUN;
                            busy        <= 1'b1;
                            count       <= CW'(WIDTH);
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and shuffled-exhaustive checks of seq_restoring_divider against
// plain integer division, including latency, hold, abort and back-to-back use.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        int bc;
        bit hold_ok;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        exp_q.push_back((b == '0) ? {W{1'b1}} : W'(a / b));
        exp_q.push_back((b == '0) ? a : W'(a % b));
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        n = 1;
        bc = 0;
        hold_ok = 1'b1;
        while (!done && n < 20) begin
            if (busy) bc++;
            if (quotient !== prev_q || remainder !== prev_r) hold_ok = 1'b0;
            step();
            n++;
        end
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        chk("latency", 32'(n), (b == '0) ? 32'd1 : 32'(W + 1));
        chk("busy_cycles", 32'(bc), (b == '0) ? 32'd0 : 32'(W));
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("result_hold", 32'(hold_ok), 32'd1);
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), (b == '0) ? 32'd1 : 32'd0);
        if (b != '0)
            chk("invariant",
                32'((int'(quotient) * int'(b) + int'(remainder) == int'(a)) && (remainder < b)),
                32'd1);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        int n;
        bit seen;
        logic [7:0] pairs[256];
        logic [7:0] tmp;
        int j;

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        step();

        do_op(4'd13, 4'd4);
        step();
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("result_after_done", {24'd0, quotient, remainder}, {24'd0, 4'd3, 4'd1});

        do_op(4'd15, 4'd1);
        do_op(4'd3, 4'd9);
        do_op(4'd0, 4'd5);
        do_op(4'd15, 4'd15);
        do_op(4'd7, 4'd0);
        step();
        do_op(4'd9, 4'd2);
        step();

        // start pulse during RUN must be ignored
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        step(); n = 1;
        start = 1'b0;
        step(); n++;
        start = 1'b1; dividend = 4'd2; divisor = 4'd1;
        step(); n++;
        start = 1'b0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("ignore_latency", 32'(n), 32'(W + 1));
        chk("ignore_result", {24'd0, quotient, remainder}, {24'd0, 4'd3, 4'd1});
        step();
        chk("ignore_no_second", {30'd0, done, busy}, 32'd0);
        prev_q = 4'd3;
        prev_r = 4'd1;

        // reset two cycles into RUN aborts without done
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_outputs", {21'd0, busy, done, quotient, remainder, div_by_zero}, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        prev_q = '0;
        prev_r = '0;
        do_op(4'd9, 4'd2);

        // back-to-back: start held during the DONE cycle
        do_op(4'd5, 4'd2);
        do_op(4'd14, 4'd3);
        do_op(4'd7, 4'd0);
        do_op(4'd6, 4'd0);
        do_op(4'd8, 4'd3);

        for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) step();
            do_op(pairs[i][7:4], pairs[i][3:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
